// File: rtl/spi_cmd_bridge.sv
// Turns SPI slave byte pulses into framed single 32-bit bus reads/writes and returns read data as TX bytes.
// Build option SPI_CMD_BRIDGE_STATUS_EN: prefixes the read response with a status byte and adds err_cnt_o.

module spi_cmd_bridge #(
    parameter int ADDR_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_dv_i,
    input  logic [7:0]  rx_byte_i,
    input  logic        frame_end_i,
    output logic        tx_dv_o,
    output logic [7:0]  tx_byte_o,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i,
    output logic        busy_o
`ifdef SPI_CMD_BRIDGE_STATUS_EN
    ,
    output logic [7:0]  err_cnt_o
`endif
);

    localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
`ifdef SPI_CMD_BRIDGE_STATUS_EN
    localparam int RESP_LEN = 5;
`else
    localparam int RESP_LEN = 4;
`endif
    localparam logic [2:0] ADDR_LAST = 3'(ADDR_BYTES - 1);
    localparam logic [2:0] RESP_LAST = 3'(RESP_LEN - 1);
    localparam logic [TO_W:0] TO_LIMIT = (TO_W + 1)'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     resp_q, resp_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            abort_q, abort_d;
    logic            bus_req_q, bus_req_d;
    logic            tx_dv_q, tx_dv_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
`ifdef SPI_CMD_BRIDGE_STATUS_EN
    logic [7:0]      err_cnt_q, err_cnt_d;
`endif

    logic            counting;
    logic            to_hit;
    logic [TO_W:0]   to_next;
    logic            cmd_valid;
    logic [31:0]     rd_word;

    // Bus handshake: bus_req_o with address/we/wdata stays asserted and stable until the
    // first cycle with bus_gnt_i high; exactly one bus_rvalid_i is then expected per grant.

    always_comb begin
        counting  = (state_q == S_ADDR) || (state_q == S_WDATA) || (state_q == S_RESP);
        to_next   = {1'b0, to_cnt_q} + {{TO_W{1'b0}}, 1'b1};
        to_hit    = (TIMEOUT_CYCLES != 0) && counting && !rx_dv_i && (to_next == TO_LIMIT);
        cmd_valid = (rx_byte_i == 8'h01) || (rx_byte_i == 8'h02);
`ifdef SPI_CMD_BRIDGE_STATUS_EN
        rd_word   = bus_rdata_i;
`else
        rd_word   = bus_err_i ? 32'hFFFF_FFFF : bus_rdata_i;
`endif

        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        resp_d    = resp_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q;
        bus_req_d = bus_req_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        to_cnt_d  = '0;
`ifdef SPI_CMD_BRIDGE_STATUS_EN
        err_cnt_d = err_cnt_q;
`endif

        if (counting && !rx_dv_i) begin
            to_cnt_d = to_next[TO_W-1:0];
        end

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                cnt_d   = '0;
                if (rx_dv_i && !frame_end_i && cmd_valid) begin
                    we_d    = (rx_byte_i == 8'h01);
                    addr_d  = '0;
                    state_d = S_ADDR;
                end
            end

            S_ADDR: begin
                if (frame_end_i || (!rx_dv_i && to_hit)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (rx_dv_i) begin
                    addr_d = {addr_q[23:0], rx_byte_i};
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d = '0;
                        if (we_q) begin
                            state_d = S_WDATA;
                        end else begin
                            state_d   = S_REQ;
                            bus_req_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            S_WDATA: begin
                if (frame_end_i || (!rx_dv_i && to_hit)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (rx_dv_i) begin
                    wdata_d = {wdata_q[23:0], rx_byte_i};
                    if (cnt_q == 3'd3) begin
                        cnt_d     = '0;
                        state_d   = S_REQ;
                        bus_req_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            S_REQ: begin
                // A frame end here is remembered; the access itself is never abandoned.
                if (frame_end_i) begin
                    abort_d = 1'b1;
                end
                if (bus_gnt_i) begin
                    bus_req_d = 1'b0;
                    state_d   = S_WAIT;
                end
            end

            S_WAIT: begin
                if (frame_end_i) begin
                    abort_d = 1'b1;
                end
                if (bus_rvalid_i) begin
`ifdef SPI_CMD_BRIDGE_STATUS_EN
                    if (bus_err_i && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
`endif
                    if (!we_q && !abort_q && !frame_end_i) begin
                        state_d = S_RESP;
                        cnt_d   = '0;
                        tx_dv_d = 1'b1;
`ifdef SPI_CMD_BRIDGE_STATUS_EN
                        tx_byte_d = {7'd0, bus_err_i};
                        resp_d    = rd_word;
`else
                        tx_byte_d = rd_word[31:24];
                        resp_d    = {rd_word[23:0], 8'h00};
`endif
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
            end

            S_RESP: begin
                if (frame_end_i || (!rx_dv_i && to_hit)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (rx_dv_i) begin
                    if (cnt_q == RESP_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        tx_dv_d   = 1'b1;
                        tx_byte_d = resp_q[31:24];
                        resp_d    = {resp_q[23:0], 8'h00};
                        cnt_d     = cnt_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            resp_q    <= '0;
            cnt_q     <= '0;
            to_cnt_q  <= '0;
            abort_q   <= 1'b0;
            bus_req_q <= 1'b0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
`ifdef SPI_CMD_BRIDGE_STATUS_EN
            err_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            resp_q    <= resp_d;
            cnt_q     <= cnt_d;
            to_cnt_q  <= to_cnt_d;
            abort_q   <= abort_d;
            bus_req_q <= bus_req_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
`ifdef SPI_CMD_BRIDGE_STATUS_EN
            err_cnt_q <= err_cnt_d;
`endif
        end
    end

    assign tx_dv_o     = tx_dv_q;
    assign tx_byte_o   = tx_byte_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = {addr_q[31:2], 2'b00};
    assign bus_be_o    = 4'hF;
    assign bus_wdata_o = wdata_q;
    assign busy_o      = (state_q != S_IDLE);
`ifdef SPI_CMD_BRIDGE_STATUS_EN
    assign err_cnt_o   = err_cnt_q;
`endif

endmodule

// File: tb/tb_spi_cmd_bridge.sv
// Directed plus randomized frames for spi_cmd_bridge, checked against a frame-level model.
module tb_spi_cmd_bridge;

  localparam int ADDR_BYTES = 4;
  localparam int TIMEOUT_CYCLES = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic frame_end = 1'b0;
  logic tx_dv_o;
  logic [7:0] tx_byte_o;
  logic bus_req_o;
  logic bus_gnt = 1'b0;
  logic bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0] bus_be_o;
  logic [31:0] bus_wdata_o;
  logic bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic bus_err = 1'b0;
  logic busy_o;
`ifdef SPI_CMD_BRIDGE_STATUS_EN
  logic [7:0] err_cnt_o;
  int exp_err = 0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int tx_pulses = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;
  logic [7:0] exp_q[$];

  spi_cmd_bridge #(
    .ADDR_BYTES(ADDR_BYTES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .rx_dv_i(rx_dv),
    .rx_byte_i(rx_byte),
    .frame_end_i(frame_end),
    .tx_dv_o(tx_dv_o),
    .tx_byte_o(tx_byte_o),
    .bus_req_o(bus_req_o),
    .bus_gnt_i(bus_gnt),
    .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_rvalid_i(bus_rvalid),
    .bus_rdata_i(bus_rdata),
    .bus_err_i(bus_err),
    .busy_o(busy_o)
`ifdef SPI_CMD_BRIDGE_STATUS_EN
    ,
    .err_cnt_o(err_cnt_o)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // passive monitor: every tx pulse and every bus request start
  always @(negedge clk) begin
    if (tx_dv_o) tx_pulses <= tx_pulses + 1;
    if (bus_req_o && !req_prev) req_rises <= req_rises + 1;
    req_prev <= bus_req_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic gap();
    idle($urandom_range(0, 3));
  endtask

  task automatic send(input logic [7:0] b);
    rx_dv = 1'b1;
    rx_byte = b;
    tick();
    rx_dv = 1'b0;
  endtask

  // reference: bytes the SPI master should see for one completed read
  task automatic fill_exp(input logic [31:0] rdata, input logic err);
    logic [31:0] w;
    exp_q.delete();
`ifdef SPI_CMD_BRIDGE_STATUS_EN
    exp_q.push_back({7'd0, err});
    w = rdata;
`else
    w = err ? 32'hFFFF_FFFF : rdata;
`endif
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
  endtask

  function automatic logic [31:0] exp_addr(input logic [31:0] a);
    logic [31:0] m;
    m = (ADDR_BYTES >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * ADDR_BYTES)) - 32'd1);
    return (a & m) & 32'hFFFF_FFFC;
  endfunction

  // One full frame plus bus handshake; data is wdata for writes and rdata for reads.
  task automatic run_frame(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           input logic err, input int gd, input int rd,
                           input bit fe_wait, input bit stray, input bit fe_resp);
    int tx0, rq0, exp_pulses;
    logic [31:0] ea;
    tx0 = tx_pulses;
    rq0 = req_rises;
    ea = exp_addr(addr);
    send(we ? 8'h01 : 8'h02);
    check("busy_after_cmd", 32'(busy_o), 32'd1);
    for (int i = ADDR_BYTES - 1; i >= 0; i--) begin
      gap();
      send(addr[8*i +: 8]);
    end
    if (we) begin
      for (int i = 3; i >= 0; i--) begin
        gap();
        send(data[8*i +: 8]);
      end
    end
    check("req_latency", 32'(bus_req_o), 32'd1);
    check("req_addr", bus_addr_o, ea);
    check("req_we", 32'(bus_we_o), 32'(we));
    check("req_be", 32'(bus_be_o), 32'hF);
    if (we) check("req_wdata", bus_wdata_o, data);
    repeat (gd) begin
      tick();
      check("req_hold", 32'(bus_req_o), 32'd1);
      check("addr_hold", bus_addr_o, ea);
    end
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    check("req_drop", 32'(bus_req_o), 32'd0);
    if (fe_wait) frame_end = 1'b1;
    idle(rd);
    if (stray) begin
      send(8'h01);
      check("stray_no_tx", 32'(tx_dv_o), 32'd0);
    end
    bus_rvalid = 1'b1;
    bus_rdata = we ? $urandom : data;
    bus_err = err;
    tick();
    bus_rvalid = 1'b0;
    bus_err = 1'b0;
    bus_rdata = $urandom;
`ifdef SPI_CMD_BRIDGE_STATUS_EN
    if (err && exp_err < 255) exp_err++;
    check("err_cnt", 32'(err_cnt_o), 32'(exp_err));
`endif
    if (we || fe_wait) begin
      exp_pulses = 0;
      check("no_tx_after_rvalid", 32'(tx_dv_o), 32'd0);
      check("idle_after_rvalid", 32'(busy_o), 32'd0);
    end else begin
      fill_exp(data, err);
      check("tx_first_valid", 32'(tx_dv_o), 32'd1);
      check("tx_first_byte", 32'(tx_byte_o), 32'(exp_q[0]));
      if (fe_resp) begin
        exp_pulses = 1;
        gap();
        frame_end = 1'b1;
        tick();
        check("resp_abort_idle", 32'(busy_o), 32'd0);
      end else begin
        exp_pulses = exp_q.size();
        for (int i = 1; i < exp_q.size(); i++) begin
          gap();
          send(8'($urandom));
          check("tx_valid", 32'(tx_dv_o), 32'd1);
          check("tx_byte", 32'(tx_byte_o), 32'(exp_q[i]));
        end
        gap();
        send(8'($urandom));
        check("resp_end_no_tx", 32'(tx_dv_o), 32'd0);
        check("resp_end_idle", 32'(busy_o), 32'd0);
      end
    end
    frame_end = 1'b0;
    idle(1);
    check("tx_pulse_count", 32'(tx_pulses - tx0), 32'(exp_pulses));
    check("req_count", 32'(req_rises - rq0), 32'd1);
  endtask

  initial begin
    int rq0;
    // reset
    rst_n = 1'b0;
    idle(3);
    check("rst_req", 32'(bus_req_o), 32'd0);
    check("rst_tx_dv", 32'(tx_dv_o), 32'd0);
    check("rst_tx_byte", 32'(tx_byte_o), 32'd0);
    check("rst_be", 32'(bus_be_o), 32'hF);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_addr", bus_addr_o, 32'd0);
    check("rst_we", 32'(bus_we_o), 32'd0);
    check("rst_wdata", bus_wdata_o, 32'd0);
`ifdef SPI_CMD_BRIDGE_STATUS_EN
    check("rst_err_cnt", 32'(err_cnt_o), 32'd0);
`endif
    rst_n = 1'b1;
    idle(2);

    // directed write and reads
    run_frame(1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 2, 3, 1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 32'h0000_1000, 32'hCAFE_F00D, 1'b0, 1, 2, 1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 32'h0000_2004, 32'h1357_9BDF, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0);

    // abort after two address bytes, then a clean write
    rq0 = req_rises;
    send(8'h01);
    send(8'hAA);
    send(8'hBB);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("abort_idle", 32'(busy_o), 32'd0);
    run_frame(1'b1, 32'h0000_2000, 32'h0102_0304, 1'b0, 1, 1, 1'b0, 1'b0, 1'b0);
    check("abort_one_req", 32'(req_rises - rq0), 32'd1);

    // frame_end and rx_dv together: frame_end wins
    send(8'h01);
    send(8'h11);
    frame_end = 1'b1;
    rx_dv = 1'b1;
    rx_byte = 8'h22;
    tick();
    rx_dv = 1'b0;
    check("fe_wins_addr", 32'(busy_o), 32'd0);
    rx_dv = 1'b1;
    rx_byte = 8'h01;
    tick();
    rx_dv = 1'b0;
    frame_end = 1'b0;
    check("fe_wins_idle", 32'(busy_o), 32'd0);

    // timeout after one address byte
    send(8'h01);
    send(8'h5A);
    idle(TIMEOUT_CYCLES - 1);
    check("to_busy_before", 32'(busy_o), 32'd1);
    tick();
    check("to_idle", 32'(busy_o), 32'd0);
    check("to_no_req", 32'(bus_req_o), 32'd0);

    // invalid command, then a valid write
    send(8'h7F);
    check("bad_cmd_idle", 32'(busy_o), 32'd0);
    run_frame(1'b1, 32'hA5A5_0010, 32'h55AA_33CC, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);

    // frame_end during WAIT and during RESP
    run_frame(1'b0, 32'h0000_0040, 32'h8899_AABB, 1'b0, 1, 2, 1'b1, 1'b0, 1'b0);
    run_frame(1'b0, 32'h0000_0080, 32'h7766_5544, 1'b0, 0, 1, 1'b0, 1'b1, 1'b1);

    // reset while REQ, then while WAIT with a late rvalid
    send(8'h02);
    for (int i = 0; i < ADDR_BYTES; i++) send(8'h10);
    check("pre_rst_req", 32'(bus_req_o), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_req_clear", 32'(bus_req_o), 32'd0);
    check("rst_req_busy", 32'(busy_o), 32'd0);
    send(8'h02);
    for (int i = 0; i < ADDR_BYTES; i++) send(8'h20);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`ifdef SPI_CMD_BRIDGE_STATUS_EN
    exp_err = 0;
`endif
    check("rst_wait_req", 32'(bus_req_o), 32'd0);
    check("rst_wait_tx", 32'(tx_dv_o), 32'd0);
    check("rst_wait_busy", 32'(busy_o), 32'd0);
    bus_rvalid = 1'b1;
    bus_rdata = 32'h1111_2222;
    tick();
    bus_rvalid = 1'b0;
    check("late_rvalid_tx", 32'(tx_dv_o), 32'd0);
    check("late_rvalid_busy", 32'(busy_o), 32'd0);
    idle(2);

    // randomized frames
    for (int n = 0; n < 24; n++) begin
      logic we, err;
      bit fe_w, st, fe_r;
      we = 1'($urandom_range(0, 1));
      err = ($urandom_range(0, 3) == 0);
      fe_w = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 3) == 0);
      fe_r = !we && ($urandom_range(0, 7) == 0);
      run_frame(we, $urandom, $urandom, err, $urandom_range(0, 4), $urandom_range(0, 4),
                fe_w, st, fe_r);
      idle($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
